video_fetch_sched: RTL and testbench

- Downstream consumer of the video mode decoder's bandwidth output.
- Turns the one-hot mode set, via mode_bw, into a per-line DRAM fetch schedule.
- Issues req/ack fetch requests to the DRAM arbiter and buffers returned words in a small FIFO.
- Hands words to the pixel renderer on demand.

---
 rtl/video_pkg.sv | 23 ++
 rtl/video_fetch_fifo.sv | 65 ++++++
 rtl/video_fetch_sched.sv | 191 +++++++++++++++++++
 tb/tb_video_fetch_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video fetch definitions: bandwidth codes, fetch FSM states, default sizing.
package video_pkg;

  localparam logic [1:0] BW_1_8 = 2'b00;
  localparam logic [1:0] BW_1_4 = 2'b01;
  localparam logic [1:0] BW_1_2 = 2'b10;
  localparam logic [1:0] BW_1_1 = 2'b11;

  localparam int VF_BASE_WORDS = 16;
  localparam int VF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  // Divider bits that must be zero for a request opportunity: 8/4/2/1 slots.
  function automatic logic [2:0] slot_mask(input logic [1:0] bw);
    return 3'b111 >> bw;
  endfunction

endpackage

// File: rtl/video_fetch_fifo.sv
// Word buffer between DRAM returns and the pixel renderer; head is registered
// so it holds its last value while empty.
module video_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_head;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rptr_nxt;
  logic [AW:0]   w_remain;

  assign w_pop      = pop && (r_count != '0);
  assign w_push     = push && ((r_count != CNT_FULL) || w_pop);
  assign w_rptr_nxt = r_rptr + AW'(w_pop);
  assign w_remain   = r_count - (AW+1)'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      r_rptr  <= w_rptr_nxt;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      // Next head comes from storage if words remain, else from the word being pushed.
      if (w_remain != '0)
        r_head <= r_mem[w_rptr_nxt];
      else if (w_push)
        r_head <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end

  assign head  = r_head;
  assign count = r_count;

endmodule

// File: rtl/video_fetch_sched.sv
// Per-line DRAM fetch scheduler feeding the pixel renderer through a small FIFO.
// Optional VFETCH_UNDERRUN_EN adds sticky underrun flag and saturating counter.
module video_fetch_sched
  import video_pkg::*;
#(
  parameter int BASE_WORDS = VF_BASE_WORDS,
  parameter int FIFO_DEPTH = VF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_bw,
  input  logic        line_start,
  input  logic        slot_tick,
  output logic        req,
  input  logic        ack,
  output logic        addr_inc,
  input  logic        rd_strobe,
  input  logic [15:0] rd_data,
  input  logic        pix_take,
  output logic [15:0] pix_word,
  output logic        pix_valid,
  output logic        line_done
`ifdef VFETCH_UNDERRUN_EN
 ,output logic        underrun,
  output logic [7:0]  underrun_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QD = 2 * FIFO_DEPTH;
  localparam int QW = $clog2(QD);

  if (BASE_WORDS < 1 || BASE_WORDS > 31) begin : g_bad_base
    $error("video_fetch_sched: BASE_WORDS must be in 1..31");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("video_fetch_sched: FIFO_DEPTH must be a power of two in 2..8");
  end

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [1:0]    r_bw;
  logic [2:0]    r_slot;
  logic [7:0]    r_words_left;
  logic [CW-1:0] r_outst;
  logic          r_req;
  logic          r_addr_inc;
  logic          r_line_done;
  logic          r_tag;

  // Tags of in-flight requests, in issue order, so stale returns can be dropped.
  logic [QD-1:0] r_tagq;
  logic [QW-1:0] r_tq_wr;
  logic [QW-1:0] r_tq_rd;
  logic [QW:0]   r_inflight;

  logic [CW-1:0] w_fifo_cnt;
  logic [15:0]   w_head;
  logic          w_acc;
  logic          w_opp;
  logic          w_room;
  logic          w_issue;
  logic          w_ret;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_valid;

  assign w_valid = (w_fifo_cnt != '0);
  assign w_acc   = r_req && ack && !line_start;
  assign w_opp   = slot_tick && ((r_slot & slot_mask(r_bw)) == 3'b000);
  assign w_room  = ((CW+1)'(w_fifo_cnt) + (CW+1)'(r_outst)) < (CW+1)'(FIFO_DEPTH);
  assign w_issue = (r_state == FS_RUN) && w_opp && !r_req && (r_words_left != 8'd0) && w_room;
  assign w_ret   = rd_strobe && (r_inflight != '0);
  assign w_push  = w_ret && (r_tagq[r_tq_rd] == r_tag) && (r_outst != '0) && !line_start;
  assign w_pop   = pix_take && w_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FS_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    if (line_start) begin
      w_state_nxt = FS_RUN;
    end else begin
      case (r_state)
        FS_RUN:  if (r_words_left == 8'd0 && !r_req) w_state_nxt = FS_WAIT;
        FS_WAIT: if (r_outst == '0) begin
          w_state_nxt = FS_IDLE;
          w_done      = 1'b1;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bw         <= BW_1_8;
      r_slot       <= '0;
      r_words_left <= '0;
      r_outst      <= '0;
      r_req        <= 1'b0;
      r_addr_inc   <= 1'b0;
      r_tag        <= 1'b0;
    end else if (line_start) begin
      r_bw         <= mode_bw;
      r_slot       <= '0;
      r_words_left <= 8'(BASE_WORDS) << mode_bw;
      r_outst      <= '0;
      r_req        <= 1'b0;
      r_addr_inc   <= 1'b0;
      r_tag        <= ~r_tag;
    end else begin
      if (slot_tick) r_slot <= r_slot + 1'b1;
      if (w_acc)        r_req <= 1'b0;
      else if (w_issue) r_req <= 1'b1;
      r_addr_inc <= w_acc;
      if (w_acc) r_words_left <= r_words_left - 1'b1;
      r_outst <= r_outst + CW'(w_acc) - CW'(w_push);
    end
  end

  // Returns are consumed from the tag queue even across line_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tagq     <= '0;
      r_tq_wr    <= '0;
      r_tq_rd    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_acc) begin
        r_tagq[r_tq_wr] <= r_tag;
        r_tq_wr         <= r_tq_wr + 1'b1;
      end
      if (w_ret) r_tq_rd <= r_tq_rd + 1'b1;
      r_inflight <= r_inflight + (QW+1)'(w_acc) - (QW+1)'(w_ret);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_line_done <= 1'b0;
    else     r_line_done <= w_done;
  end

  video_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (line_start),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (rd_data),
    .head  (w_head),
    .count (w_fifo_cnt)
  );

`ifdef VFETCH_UNDERRUN_EN
  logic       r_underrun;
  logic [7:0] r_under_cnt;
  logic       w_under;

  assign w_under = pix_take && !w_valid && (r_state == FS_RUN || r_state == FS_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun  <= 1'b0;
      r_under_cnt <= '0;
    end else if (w_under) begin
      r_underrun <= 1'b1;
      if (r_under_cnt != 8'hFF) r_under_cnt <= r_under_cnt + 1'b1;
    end
  end

  assign underrun     = r_underrun;
  assign underrun_cnt = r_under_cnt;
`endif

  assign req       = r_req;
  assign addr_inc  = r_addr_inc;
  assign pix_word  = w_head;
  assign pix_valid = w_valid;
  assign line_done = r_line_done;

endmodule

// File: tb/tb_video_fetch_sched.sv
// Cycle-stepped bench: DRAM return model + renderer, scoreboard of expected words.
module tb_video_fetch_sched;
  import video_pkg::*;

  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_bw = 2'b00;
  logic        line_start = 1'b0;
  logic        slot_tick = 1'b0;
  logic        ack = 1'b0;
  logic        rd_strobe = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic        pix_take = 1'b0;
  logic        req, addr_inc, pix_valid, line_done;
  logic [15:0] pix_word;
`ifdef VFETCH_UNDERRUN_EN
  logic        underrun;
  logic [7:0]  underrun_cnt;
`endif

  video_fetch_sched #(.BASE_WORDS(BASE), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_bw    (mode_bw),
    .line_start (line_start),
    .slot_tick  (slot_tick),
    .req        (req),
    .ack        (ack),
    .addr_inc   (addr_inc),
    .rd_strobe  (rd_strobe),
    .rd_data    (rd_data),
    .pix_take   (pix_take),
    .pix_word   (pix_word),
    .pix_valid  (pix_valid),
    .line_done  (line_done)
`ifdef VFETCH_UNDERRUN_EN
   ,.underrun     (underrun),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          stale;
  } ret_t;

  ret_t        ret_q[$];
  logic [15:0] exp_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_addr = 0, n_done = 0, n_pop = 0, n_push = 0, last_addr = -1;
  int slot_per = 1, rd_dly = 2, ack_lim = 1 << 30, n_ack_ph = 0, spacing_exp = 0;
  int take_mode = 0, line_words = 0;
  bit ack_en = 1'b1, take_once = 1'b0, do_ls = 1'b0;
  logic [15:0] next_data = 16'h1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    ret_t r;
    logic ls;
    @(negedge clk);
    cyc++;
    if (addr_inc) begin
      if (spacing_exp != 0 && last_addr >= 0) chk("addr_spacing", cyc - last_addr, spacing_exp);
      last_addr = cyc;
      n_addr++;
    end
    if (line_done) begin
      n_done++;
      chk("done_after_last_push", n_push, line_words);
    end
    ls = do_ls;
    do_ls = 1'b0;
    if (ls) begin
      foreach (ret_q[i]) ret_q[i].stale = 1'b1;
      exp_q.delete();
      last_addr = -1; n_ack_ph = 0; n_push = 0; n_pop = 0; n_addr = 0;
    end
    ack = (req && ack_en && n_ack_ph < ack_lim) || (ls && req);
    if (ack && !ls) begin
      ret_q.push_back('{cyc + rd_dly, next_data, 1'b0});
      next_data++;
      n_ack_ph++;
    end
    r = '{0, 16'h0, 1'b0};
    rd_strobe = 1'b0;
    rd_data = 16'h0;
    if (!ls && ret_q.size() != 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      rd_strobe = 1'b1;
      rd_data = r.data;
    end
    pix_take = take_once || (take_mode == 1) || (take_mode == 2 && rd_strobe);
    take_once = 1'b0;
    if (ls) pix_take = 1'b0;
    if (pix_take && pix_valid) begin
      chk("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("pix_word", pix_word, exp_q.pop_front());
      n_pop++;
    end
    if (rd_strobe && !r.stale) begin
      exp_q.push_back(r.data);
      n_push++;
    end
    slot_tick = !ls && slot_per != 0 && (cyc % slot_per == 0);
    line_start = ls;
  endtask

  task automatic start_line();
    line_words = BASE << mode_bw;
    do_ls = 1'b1;
    step();
  endtask

  task automatic run_line(input string tag);
    int base;
    base = n_done;
    for (int i = 0; i < 4000 && n_done == base; i++) step();
    repeat (20) step();
    chk({tag, "_done_once"}, n_done - base, 1);
    chk({tag, "_addr_count"}, n_addr, line_words);
    chk({tag, "_push_count"}, n_push, line_words);
    chk({tag, "_pop_count"}, n_pop, line_words);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", req, 0);
    chk("rst_addr_inc", addr_inc, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_word", pix_word, 0);
    chk("rst_line_done", line_done, 0);

    // 1/8 bandwidth, immediate ack, renderer always taking
    mode_bw = BW_1_8; slot_per = 2; rd_dly = 2; take_mode = 1; spacing_exp = 16;
    start_line();
    run_line("t1");

    // mode change mid-line must not affect the current line
    start_line();
    repeat (20) step();
    mode_bw = BW_1_1;
    run_line("t3");
    spacing_exp = 0;

    // full bandwidth with a stalled renderer
    slot_per = 1; take_mode = 0;
    start_line();
    repeat (40) step();
    chk("t2_stall_acks", n_addr, 4);
    chk("t2_stall_req", req, 0);
    chk("t2_full_valid", pix_valid, 1);
    take_once = 1'b1;
    step();
    repeat (10) step();
    chk("t2_resume_acks", n_addr, 5);
    // pops only coincident with returns: push+pop in the same clk
    take_mode = 2; take_once = 1'b1;
    repeat (60) step();
    chk("t5_valid", pix_valid, 1);
    chk("t5_progress", n_addr > 10, 1);
    take_mode = 1;
    run_line("t2");

    // line_start with one word buffered, two outstanding and a pending req
    take_mode = 0; rd_dly = 2; ack_lim = 1;
    start_line();
    for (int i = 0; i < 60 && !(n_addr == 1 && pix_valid); i++) step();
    rd_dly = 30; ack_lim = 3;
    for (int i = 0; i < 60 && !(n_addr == 3 && req); i++) step();
    chk("t4_setup_addr", n_addr, 3);
    chk("t4_setup_req", req, 1);
    chk("t4_setup_valid", pix_valid, 1);
    rd_dly = 2; ack_lim = 1 << 30; mode_bw = BW_1_8; take_mode = 1;
    start_line();
    step();
    chk("t4_req_drop", req, 0);
    chk("t4_no_addr_inc", addr_inc, 0);
    chk("t4_flushed", pix_valid, 0);
    run_line("t4");

`ifdef VFETCH_UNDERRUN_EN
    rst = 1'b1;
    ret_q.delete(); exp_q.delete();
    step();
    rst = 1'b0;
    slot_per = 0; take_mode = 0; mode_bw = BW_1_8;
    start_line();
    step();
    repeat (3) begin
      take_once = 1'b1;
      step();
    end
    step(); step();
    chk("t6_underrun", underrun, 1);
    chk("t6_underrun_cnt", underrun_cnt, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_underrun", underrun, 0);
    chk("t6_rst_underrun_cnt", underrun_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
